// File: rtl/unshift_buffer.sv
// unshift_buffer: wide word to narrow lane stream, lane 0 first; UNSHIFT_BUFFER_BACK_TO_BACK_EN allows accept on the final beat
module unshift_buffer #(
   parameter int buffer_SIZE  = 8,
   parameter int buffer_WIDTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [buffer_WIDTH*buffer_SIZE-1:0]  data_i,
   input  logic                                 data_valid_i,
   output logic                                 data_ready_o,
   output logic [buffer_WIDTH-1:0]              data_o,
   output logic                                 data_valid_o,
   input  logic                                 ready_i,
   output logic                                 last_o
);
   localparam int CW = $clog2(buffer_SIZE);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                              state;
   logic [buffer_WIDTH*buffer_SIZE-1:0] shreg;
   logic [CW-1:0]                       cnt;
   logic                                last_cnt;
   assign last_cnt     = cnt == CW'(buffer_SIZE - 1);
   assign data_valid_o = state == SEND;
   assign last_o       = data_valid_o && last_cnt;
   assign data_o       = shreg[buffer_WIDTH-1:0];
`ifdef UNSHIFT_BUFFER_BACK_TO_BACK_EN
   assign data_ready_o = state == IDLE || (ready_i && last_cnt);
`else
   assign data_ready_o = state == IDLE;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else if (data_valid_i && data_ready_o) begin
         state <= SEND;
         cnt   <= '0;
         shreg <= data_i;
      end else if (data_valid_o && ready_i) begin
         if (last_cnt) state <= IDLE;
         else begin
            shreg <= shreg >> buffer_WIDTH;
            cnt   <= cnt + 1'b1;
         end
      end
   end
endmodule
